xor_share_arbiter: RTL

- Shares one combining datapath (c = doit ? a ^ b : 0) among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes; each requester's doit setting comes from a per-requester parameter mask.
- One-entry registered output stage tagged with the requester id.
- Sits between requester blocks and a single downstream consumer.

---
 rtl/xor_share_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter that shares one XOR datapath among NREQ requesters.
// Results go out through a one-entry output register tagged with the requester id.
module xor_share_arbiter #(
    parameter int               NREQ      = 2,
    parameter int               WIDTH     = 8,
    parameter logic [NREQ-1:0]  DOIT_MASK = '1,
    localparam int              ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic [15:0]             busy_cnt
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [ID_W:0] NREQ_W = (ID_W + 1)'(NREQ);

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     r_id;
    logic [WIDTH-1:0]    r_data;
    logic [15:0]         r_busy;

    logic                w_slot_free;
    logic                w_found;
    logic                w_accept;
    logic                w_doit;
    logic [2*NREQ-1:0]   w_req_dbl;
    logic [NREQ-1:0]     w_rot;
    logic [ID_W:0]       w_shift;
    logic [ID_W:0]       w_off;
    logic [ID_W:0]       w_sum;
    logic [ID_W-1:0]     w_grant_id;
    logic [WIDTH-1:0]    w_a;
    logic [WIDTH-1:0]    w_b;
    logic [WIDTH-1:0]    w_result;

    assign w_slot_free = (r_state == ST_EMPTY) || rsp_ready;

    // Rotate the request vector so bit 0 is the requester just after the last winner.
    assign w_req_dbl = {req_valid, req_valid};
    assign w_shift   = {1'b0, r_last} + (ID_W + 1)'(1);
    assign w_rot     = NREQ'(w_req_dbl >> w_shift);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = (ID_W + 1)'(k);
            end
        end
    end

    assign w_sum      = w_shift + w_off;
    assign w_grant_id = (w_sum >= NREQ_W) ? ID_W'(w_sum - NREQ_W) : ID_W'(w_sum);
    assign w_accept   = w_found && w_slot_free;
    assign req_ready  = w_accept ? (NREQ'(1) << w_grant_id) : '0;

    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_doit = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant_id == ID_W'(k)) begin
                w_a    = req_a[k*WIDTH +: WIDTH];
                w_b    = req_b[k*WIDTH +: WIDTH];
                w_doit = DOIT_MASK[k];
            end
        end
    end

    assign w_result = w_doit ? (w_a ^ w_b) : '0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
            ST_FULL: begin
                if (w_accept)       w_state_next = ST_FULL;
                else if (rsp_ready) w_state_next = ST_EMPTY;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_last  <= ID_W'(NREQ - 1);
            r_id    <= '0;
            r_data  <= '0;
            r_busy  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_last <= w_grant_id;
                r_id   <= w_grant_id;
                r_data <= w_result;
            end
            if ((r_state == ST_FULL) && !rsp_ready && (r_busy != 16'hFFFF))
                r_busy <= r_busy + 16'd1;
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;
    assign busy_cnt  = r_busy;

endmodule
